// File: rtl/com_config_scan_shifter_pkg.sv
// Shared types and constants for the config scan-chain shifter.
// The FSM state enum and array-select codes are used by the RTL and the bench.
package com_cfg_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } scan_state_t;

  localparam logic [1:0] ARR_SEL_0       = 2'd0;
  localparam logic [1:0] ARR_SEL_1       = 2'd1;
  localparam logic [1:0] ARR_SEL_2       = 2'd2;
  localparam logic [1:0] ARR_SEL_ILLEGAL = 2'd3;

  localparam int CFG_N_WORDS = 256;
  localparam int CFG_WORD_W  = 16;

  typedef logic [CFG_N_WORDS-1:0][CFG_WORD_W-1:0] cfg_array_t;

endpackage

// File: rtl/com_config_scan_shifter_phase_cnt.sv
// Divides fw_clk_100 into scan_clk half-periods: counts 0..CLK_DIV-1 while enabled
// and raises tick on the last count so the FSM steps once per half-period.
module com_scan_phase_cnt #(
  parameter int CLK_DIV = 4
) (
  input  logic fw_clk_100,
  input  logic fw_rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick = en && !clr && (cnt_reg == CNT_MAX);

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge fw_clk_100) begin
    if (!fw_rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/com_config_scan_shifter.sv
// Serializes one of three cfg arrays onto the chip scan chain (scan_clk/scan_din/scan_load),
// word 0 first, MSB first, with a scan_load strobe after the last bit.
module com_config_scan_shifter
  import com_cfg_scan_pkg::*;
#(
  parameter int N_WORDS = 256,
  parameter int WORD_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                                fw_clk_100,
  input  logic                                fw_rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [1:0]                          array_sel,
  input  logic [$clog2(N_WORDS+1)-1:0]        num_words,
  input  logic [N_WORDS-1:0][WORD_W-1:0]      cfg_array_0,
  input  logic [N_WORDS-1:0][WORD_W-1:0]      cfg_array_1,
  input  logic [N_WORDS-1:0][WORD_W-1:0]      cfg_array_2,
  output logic                                scan_clk,
  output logic                                scan_din,
  output logic                                scan_load,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int IDX_W = $clog2(N_WORDS + 1);
  localparam int RD_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  scan_state_t       state_reg, state_next;
  logic [1:0]        sel_reg, sel_next;
  logic [IDX_W-1:0]  num_words_reg, num_words_next;
  logic [IDX_W-1:0]  word_idx_reg, word_idx_next;
  logic [BIT_W-1:0]  bit_idx_reg, bit_idx_next;
  logic [WORD_W-1:0] shift_reg, shift_next;
  logic              latch_half_reg, latch_half_next;

  logic scan_clk_reg, scan_clk_next;
  logic scan_din_reg, scan_din_next;
  logic scan_load_reg, scan_load_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic err_reg, err_next;

  logic              phase_en;
  logic              phase_clr;
  logic              tick;
  logic              args_ok;
  logic              last_bit;
  logic              last_word;
  logic [IDX_W-1:0]  word_idx_inc;
  logic [1:0]        rd_sel;
  logic [RD_W-1:0]   rd_idx;
  logic [WORD_W-1:0] rd_word;

  assign phase_en  = (state_reg == SHIFT_LO) || (state_reg == SHIFT_HI) || (state_reg == LATCH);
  assign phase_clr = !phase_en || abort;

  com_scan_phase_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_cnt (
    .fw_clk_100 (fw_clk_100),
    .fw_rst_n   (fw_rst_n),
    .clr        (phase_clr),
    .en         (phase_en),
    .tick       (tick)
  );

  assign args_ok = (array_sel != ARR_SEL_ILLEGAL) && (num_words != '0)
                && (num_words <= IDX_W'(N_WORDS));
  assign last_bit     = (bit_idx_reg == BIT_W'(WORD_W - 1));
  assign last_word    = (word_idx_reg == num_words_reg - IDX_W'(1));
  assign word_idx_inc = word_idx_reg + IDX_W'(1);

  // Words are fetched live at the moment their MSB goes out, so the array is never snapshotted.
  always_comb begin
    rd_sel = (state_reg == IDLE) ? array_sel : sel_reg;
    rd_idx = (state_reg == IDLE) ? '0 : word_idx_inc[RD_W-1:0];
    case (rd_sel)
      ARR_SEL_0: rd_word = cfg_array_0[rd_idx];
      ARR_SEL_1: rd_word = cfg_array_1[rd_idx];
      ARR_SEL_2: rd_word = cfg_array_2[rd_idx];
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge fw_clk_100) begin
    if (!fw_rst_n) begin
      state_reg      <= IDLE;
      sel_reg        <= '0;
      num_words_reg  <= '0;
      word_idx_reg   <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      latch_half_reg <= 1'b0;
      scan_clk_reg   <= 1'b0;
      scan_din_reg   <= 1'b0;
      scan_load_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      num_words_reg  <= num_words_next;
      word_idx_reg   <= word_idx_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      latch_half_reg <= latch_half_next;
      scan_clk_reg   <= scan_clk_next;
      scan_din_reg   <= scan_din_next;
      scan_load_reg  <= scan_load_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    num_words_next  = num_words_reg;
    word_idx_next   = word_idx_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    latch_half_next = latch_half_reg;
    err_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          if (args_ok) begin
            state_next     = SHIFT_LO;
            sel_next       = array_sel;
            num_words_next = num_words;
            word_idx_next  = '0;
            bit_idx_next   = '0;
            shift_next     = rd_word;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SHIFT_LO: begin
        if (tick) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          if (last_bit && last_word) begin
            state_next      = LATCH;
            latch_half_next = 1'b0;
          end else begin
            state_next   = SHIFT_LO;
            bit_idx_next = last_bit ? '0 : bit_idx_reg + BIT_W'(1);
            if (last_bit) begin
              word_idx_next = word_idx_inc;
              shift_next    = rd_word;
            end else begin
              shift_next = {shift_reg[WORD_W-2:0], 1'b0};
            end
          end
        end
      end
      // scan_load spans two half-periods; latch_half_reg marks the second one.
      LATCH: begin
        if (tick) begin
          latch_half_next = !latch_half_reg;
          if (latch_half_reg) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (abort && phase_en) begin
      state_next = IDLE;
    end
  end

  // Outputs are decoded from the next state and registered, keeping the pads glitch-free.
  always_comb begin
    scan_clk_next  = (state_next == SHIFT_HI);
    scan_din_next  = ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) ? shift_next[WORD_W-1] : 1'b0;
    scan_load_next = (state_next == LATCH);
    busy_next      = (state_next == SHIFT_LO) || (state_next == SHIFT_HI) || (state_next == LATCH);
    done_next      = (state_next == DONE);
  end

  assign scan_clk  = scan_clk_reg;
  assign scan_din  = scan_din_reg;
  assign scan_load = scan_load_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_com_config_scan_shifter.sv
// Randomized bench for com_config_scan_shifter: a negedge monitor captures the scan stream
// and pulse counts, and each scenario compares them with a bit-list model built from the arrays.
module tb_com_config_scan_shifter;
  import com_cfg_scan_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int BIT_CYC = 2 * CLK_DIV;

  logic       fw_clk_100 = 1'b0;
  logic       fw_rst_n   = 1'b0;
  logic       start      = 1'b0;
  logic       abort      = 1'b0;
  logic [1:0] array_sel  = 2'd0;
  logic [8:0] num_words  = 9'd0;
  cfg_array_t cfg_array_0, cfg_array_1, cfg_array_2;
  logic scan_clk, scan_din, scan_load, busy, done, err;

  int vectors     = 0;
  int miscompares = 0;

  com_config_scan_shifter #(
    .N_WORDS (CFG_N_WORDS),
    .WORD_W  (CFG_WORD_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .fw_clk_100  (fw_clk_100),
    .fw_rst_n    (fw_rst_n),
    .start       (start),
    .abort       (abort),
    .array_sel   (array_sel),
    .num_words   (num_words),
    .cfg_array_0 (cfg_array_0),
    .cfg_array_1 (cfg_array_1),
    .cfg_array_2 (cfg_array_2),
    .scan_clk    (scan_clk),
    .scan_din    (scan_din),
    .scan_load   (scan_load),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 fw_clk_100 = ~fw_clk_100;

  // ---------------- monitor ----------------
  bit mon_clr = 1'b1;
  bit cap_bits[$];
  bit exp_bits[$];
  int busy_cnt, load_cnt, done_cnt, err_cnt, viol_cnt;
  bit prev_clk, prev_din, prev_busy;

  always @(negedge fw_clk_100) begin
    if (mon_clr) begin
      cap_bits.delete();
      busy_cnt = 0; load_cnt = 0; done_cnt = 0; err_cnt = 0; viol_cnt = 0;
      prev_clk = 1'b0; prev_din = 1'b0; prev_busy = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (scan_load) load_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (scan_clk && !prev_clk) cap_bits.push_back(scan_din);
      if (scan_clk && prev_clk && (scan_din != prev_din)) viol_cnt++;
      if (!scan_clk && !prev_clk && busy && prev_busy && (scan_din != prev_din)) viol_cnt++;
      if (!busy && (scan_clk || scan_din || scan_load)) viol_cnt++;
      if (scan_load && (scan_clk || scan_din)) viol_cnt++;
      if (done && (busy || !prev_busy)) viol_cnt++;
      prev_clk = scan_clk; prev_din = scan_din; prev_busy = busy;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_word(input logic [1:0] sel, input int idx);
    case (sel)
      2'd0:    return cfg_array_0[idx];
      2'd1:    return cfg_array_1[idx];
      2'd2:    return cfg_array_2[idx];
      default: return 16'h0;
    endcase
  endfunction

  function automatic void build_expected(input logic [1:0] sel, input int n);
    logic [15:0] w;
    exp_bits.delete();
    for (int i = 0; i < n; i++) begin
      w = model_word(sel, i);
      for (int b = 15; b >= 0; b--) exp_bits.push_back(w[b]);
    end
  endfunction

  function automatic int bit_errors();
    int nbad = 0;
    if (cap_bits.size() != exp_bits.size()) return -1;
    for (int i = 0; i < exp_bits.size(); i++) if (cap_bits[i] != exp_bits[i]) nbad++;
    return nbad;
  endfunction

  function automatic void randomize_arrays();
    for (int i = 0; i < CFG_N_WORDS; i++) begin
      cfg_array_0[i] = 16'($urandom);
      cfg_array_1[i] = 16'($urandom);
      cfg_array_2[i] = 16'($urandom);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic mon_reset();
    mon_clr = 1'b1;
    @(negedge fw_clk_100);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] sel, input logic [8:0] n, input logic ab);
    @(posedge fw_clk_100);
    #1;
    array_sel = sel; num_words = n; start = 1'b1; abort = ab;
    @(posedge fw_clk_100);
    #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge fw_clk_100);
      if (done) begin ok = 1'b1; break; end
    end
    @(posedge fw_clk_100);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    fw_rst_n = 1'b0;
    repeat (3) @(posedge fw_clk_100);
    #1;
    vectors++;
    if ({scan_clk, scan_din, scan_load, busy, done, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 000000", {scan_clk, scan_din, scan_load, busy, done, err});
    end
    fw_rst_n = 1'b1;
    mon_reset();
    repeat (4) @(posedge fw_clk_100);
    #1;
    vectors++;
    if (busy_cnt + done_cnt + err_cnt + viol_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_idle: activity %0d required 0", busy_cnt + done_cnt + err_cnt + viol_cnt);
    end
  endtask

  task automatic test_single_word();
    bit ok;
    cfg_array_0[0] = 16'hA5C3;
    build_expected(2'd0, 1);
    mon_reset();
    pulse_start(2'd0, 9'd1, 1'b0);
    vectors++;
    if (busy !== 1'b1 || scan_clk !== 1'b0 || scan_din !== 1'b1) begin
      miscompares++;
      $display("FAIL single_latency: busy=%b clk=%b din=%b required 1 0 1", busy, scan_clk, scan_din);
    end
    wait_done(200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL single_timeout: no done within 200 cycles"); end
    vectors++;
    if (bit_errors() !== 0) begin
      miscompares++;
      $display("FAIL single_bits: %0d bad of %0d captured, required 16'hA5C3 MSB first", bit_errors(), cap_bits.size());
    end
    vectors++;
    if (busy_cnt !== 68) begin miscompares++; $display("FAIL single_busy: got %0d required 68", busy_cnt); end
    vectors++;
    if (load_cnt !== 4) begin miscompares++; $display("FAIL single_load: got %0d required 4", load_cnt); end
    vectors++;
    if (done_cnt !== 1 || viol_cnt !== 0) begin
      miscompares++;
      $display("FAIL single_done: done=%0d viol=%0d required 1 0", done_cnt, viol_cnt);
    end
  endtask

  task automatic test_full_array();
    bit ok;
    for (int i = 0; i < CFG_N_WORDS; i++) cfg_array_2[i] = 16'(i);
    build_expected(2'd2, 256);
    mon_reset();
    pulse_start(2'd2, 9'd256, 1'b0);
    wait_done(256 * 16 * BIT_CYC + 100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL full_timeout: no done"); end
    vectors++;
    if (bit_errors() !== 0) begin
      miscompares++;
      $display("FAIL full_bits: %0d bad, captured %0d required 4096", bit_errors(), cap_bits.size());
    end
    vectors++;
    if (busy_cnt !== 256 * 16 * BIT_CYC + BIT_CYC) begin
      miscompares++;
      $display("FAIL full_busy: got %0d required %0d", busy_cnt, 256 * 16 * BIT_CYC + BIT_CYC);
    end
    vectors++;
    if (done_cnt !== 1 || viol_cnt !== 0) begin
      miscompares++;
      $display("FAIL full_done: done=%0d viol=%0d required 1 0", done_cnt, viol_cnt);
    end
  endtask

  task automatic test_random_transfers();
    bit ok;
    logic [1:0] sel;
    int n;
    for (int t = 0; t < 6; t++) begin
      randomize_arrays();
      sel = 2'($urandom_range(0, 2));
      n   = $urandom_range(1, 6);
      build_expected(sel, n);
      mon_reset();
      pulse_start(sel, 9'(n), 1'b0);
      wait_done(n * 16 * BIT_CYC + 100, ok);
      vectors++;
      if (!ok || bit_errors() !== 0) begin
        miscompares++;
        $display("FAIL rand_bits[%0d]: sel=%0d n=%0d done_seen=%0d bad=%0d required 0", t, sel, n, ok, bit_errors());
      end
      vectors++;
      if (busy_cnt !== n * 16 * BIT_CYC + BIT_CYC || load_cnt !== BIT_CYC) begin
        miscompares++;
        $display("FAIL rand_timing[%0d]: busy=%0d load=%0d required %0d %0d", t, busy_cnt, load_cnt,
                 n * 16 * BIT_CYC + BIT_CYC, BIT_CYC);
      end
      vectors++;
      if (done_cnt !== 1 || err_cnt !== 0 || viol_cnt !== 0) begin
        miscompares++;
        $display("FAIL rand_pulses[%0d]: done=%0d err=%0d viol=%0d required 1 0 0", t, done_cnt, err_cnt, viol_cnt);
      end
    end
  endtask

  task automatic test_illegal_args();
    logic [1:0] sel_tab [3] = '{2'd0, 2'd3, 2'd1};
    logic [8:0] n_tab   [3];
    n_tab[0] = 9'd0;
    n_tab[1] = 9'd5;
    n_tab[2] = 9'($urandom_range(257, 511));
    for (int t = 0; t < 3; t++) begin
      mon_reset();
      pulse_start(sel_tab[t], n_tab[t], 1'b0);
      vectors++;
      if (err !== 1'b1) begin
        miscompares++;
        $display("FAIL illegal_err[%0d]: sel=%0d n=%0d err=%b required 1", t, sel_tab[t], n_tab[t], err);
      end
      repeat (6) @(posedge fw_clk_100);
      #1;
      vectors++;
      if (err_cnt !== 1 || busy_cnt !== 0 || viol_cnt !== 0) begin
        miscompares++;
        $display("FAIL illegal_quiet[%0d]: err=%0d busy=%0d viol=%0d required 1 0 0", t, err_cnt, busy_cnt, viol_cnt);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    randomize_arrays();
    mon_reset();
    pulse_start(2'd1, 9'd3, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge fw_clk_100);
      if (cap_bits.size() >= 20) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL abort_reach: got %0d bits required 20", cap_bits.size()); end
    #1 abort = 1'b1;
    @(posedge fw_clk_100);
    #1 abort = 1'b0;
    vectors++;
    if ({scan_clk, scan_din, scan_load, busy, done, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL abort_outputs: got %b required 000000", {scan_clk, scan_din, scan_load, busy, done, err});
    end
    repeat (30) @(posedge fw_clk_100);
    #1;
    vectors++;
    if (done_cnt !== 0 || busy !== 1'b0 || cap_bits.size() != 20) begin
      miscompares++;
      $display("FAIL abort_quiet: done=%0d busy=%b bits=%0d required 0 0 20", done_cnt, busy, cap_bits.size());
    end
    build_expected(2'd0, 2);
    mon_reset();
    pulse_start(2'd0, 9'd2, 1'b0);
    wait_done(400, ok);
    vectors++;
    if (!ok || bit_errors() !== 0 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL abort_restart: done_seen=%0d bad=%0d done=%0d required 1 0 1", ok, bit_errors(), done_cnt);
    end
  endtask

  task automatic test_start_abort_same_cycle();
    mon_reset();
    pulse_start(2'd0, 9'd4, 1'b1);
    repeat (8) @(posedge fw_clk_100);
    #1;
    vectors++;
    if (busy_cnt !== 0 || err_cnt !== 0 || viol_cnt !== 0) begin
      miscompares++;
      $display("FAIL start_abort: busy=%0d err=%0d viol=%0d required 0 0 0", busy_cnt, err_cnt, viol_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    randomize_arrays();
    build_expected(2'd0, 4);
    mon_reset();
    pulse_start(2'd0, 9'd4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      repeat (30) @(posedge fw_clk_100);
      #1;
      start = 1'b1; array_sel = 2'($urandom_range(1, 3)); num_words = 9'($urandom_range(0, 300));
      @(posedge fw_clk_100);
      #1 start = 1'b0;
    end
    wait_done(4 * 16 * BIT_CYC + 100, ok);
    vectors++;
    if (!ok || bit_errors() !== 0) begin
      miscompares++;
      $display("FAIL busy_start_bits: done_seen=%0d bad=%0d required 1 0", ok, bit_errors());
    end
    vectors++;
    if (busy_cnt !== 4 * 16 * BIT_CYC + BIT_CYC || err_cnt !== 0 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL busy_start_ignored: busy=%0d err=%0d done=%0d required %0d 0 1", busy_cnt, err_cnt, done_cnt,
               4 * 16 * BIT_CYC + BIT_CYC);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    randomize_arrays();
    mon_reset();
    pulse_start(2'd2, 9'd3, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge fw_clk_100);
      #1;
      if (scan_clk && cap_bits.size() >= 5) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rst_reach: SHIFT_HI not reached, bits=%0d", cap_bits.size()); end
    fw_rst_n = 1'b0;
    @(posedge fw_clk_100);
    #1;
    vectors++;
    if ({scan_clk, scan_din, scan_load, busy, done, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_outputs: got %b required 000000", {scan_clk, scan_din, scan_load, busy, done, err});
    end
    fw_rst_n = 1'b1;
    repeat (40) @(posedge fw_clk_100);
    #1;
    vectors++;
    if (done_cnt !== 0 || err_cnt !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_quiet: done=%0d err=%0d busy=%b required 0 0 0", done_cnt, err_cnt, busy);
    end
  endtask

  initial begin
    randomize_arrays();
    test_reset();
    test_single_word();
    test_full_array();
    test_random_transfers();
    test_illegal_args();
    test_abort();
    test_start_abort_same_cycle();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
